fetch_decode_stage: RTL and testbench

FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

---
 rtl/fetch_decode_stage.sv | 194 +++++++++++++++++++
 tb/tb_fetch_decode_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end: drives a synchronous instruction memory, decodes the
// returned word, reads the register file and registers the result for issue.
module fetch_decode_stage #(
  parameter  int unsigned DATA_W   = 16,
  parameter  int unsigned INSTR_W  = 24,
  parameter  int unsigned NREGS    = 16,
  parameter  int unsigned PC_W     = 16,
  parameter  int unsigned RESET_PC = 0,
  localparam int unsigned RA_W     = $clog2(NREGS)
) (
  input  logic               iclk,
  input  logic               irst_n,
  output logic [PC_W-1:0]    oImemAddr,
  input  logic [INSTR_W-1:0] iImemData,
  input  logic               iStall,
  input  logic               iRedirect,
  input  logic [PC_W-1:0]    iRedirectPC,
  input  logic               iWbEn,
  input  logic [RA_W-1:0]    iWbAddr,
  input  logic [DATA_W-1:0]  iWbData,
  output logic               oValid,
  output logic [PC_W-1:0]    oPC,
  output logic [4:0]         oOpcode,
  output logic [RA_W-1:0]    oRd,
  output logic [RA_W-1:0]    oSr1,
  output logic [RA_W-1:0]    oSr2,
  output logic [DATA_W-1:0]  oData1,
  output logic [DATA_W-1:0]  oData2,
  output logic [DATA_W-1:0]  oImm,
  output logic               oWriteReg,
  output logic               oMemRead,
  output logic               oMemWrite,
  output logic               oALUSrc
);

  typedef enum logic [4:0] {
    OP_IMML    = 5'b01000,
    OP_IMMH    = 5'b01001,
    OP_LOAD    = 5'b01010,
    OP_STORE   = 5'b01011,
    OP_DBLOAD  = 5'b01100,
    OP_DBSTORE = 5'b01101
  } opcode_e;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [4:0]        opcode;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   sr1;
    logic [RA_W-1:0]   sr2;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] imm;
    logic              writeReg;
    logic              memRead;
    logic              memWrite;
    logic              aluSrc;
  } stage_t;

  logic [PC_W-1:0]   fPC;
  logic              dValid;
  logic [PC_W-1:0]   nextPC;
  logic              hazard;
  logic              advance;
  stage_t            stageQ;
  stage_t            stageD;
  logic [DATA_W-1:0] regs [NREGS];

  logic [4:0]        dOpcode;
  logic [RA_W-1:0]   dRdField;
  logic [RA_W-1:0]   dSr1;
  logic [RA_W-1:0]   dSr2;
  logic [7:0]        dImm8;
  logic              dIsMem;
  logic              dWriteReg;
  logic [DATA_W-1:0] dImm;
  logic [DATA_W-1:0] rdData1;
  logic [DATA_W-1:0] rdData2;
  logic              unusedBits;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return DATA_W'($signed(v));
  endfunction

  // Field positions are fixed regardless of RA_W; the cast widens or narrows.
  assign dOpcode    = iImemData[4:0];
  assign dRdField   = RA_W'(iImemData[8:5]);
  assign dSr1       = RA_W'(iImemData[12:9]);
  assign dSr2       = RA_W'(iImemData[16:13]);
  assign dImm8      = iImemData[20:13];
  assign unusedBits = ^iImemData[INSTR_W-1:21];

  assign dIsMem    = (dOpcode == OP_LOAD)   || (dOpcode == OP_STORE) ||
                     (dOpcode == OP_DBLOAD) || (dOpcode == OP_DBSTORE);
  assign dWriteReg = !((dOpcode == OP_STORE) || (dOpcode == OP_DBSTORE));

  always_comb begin
    dImm = '0;
    case (dOpcode)
      OP_IMML:                                  dImm = DATA_W'(dImm8);
      OP_IMMH:                                  dImm = sext16({dImm8, 8'h00});
      OP_LOAD, OP_STORE, OP_DBLOAD, OP_DBSTORE: dImm = sext16({{8{dImm8[7]}}, dImm8});
      default:                                  dImm = '0;
    endcase
  end

  // Register 0 is hardwired; a same-cycle writeback wins over the array.
  always_comb begin
    rdData1 = '0;
    if (dSr1 != '0)
      rdData1 = (iWbEn && (iWbAddr == dSr1)) ? iWbData : regs[dSr1];
  end

  always_comb begin
    rdData2 = '0;
    if (dSr2 != '0)
      rdData2 = (iWbEn && (iWbAddr == dSr2)) ? iWbData : regs[dSr2];
  end

  assign hazard = dValid && stageQ.valid && stageQ.memRead && (stageQ.rd != '0) &&
                  ((stageQ.rd == dSr1) || (stageQ.rd == dSr2));

  // Without a fetched word (after reset or redirect) fPC is re-presented so the
  // memory returns it on the next edge.
  assign advance = dValid && !iStall && !hazard;

  always_comb begin
    if (iRedirect)
      nextPC = iRedirectPC;
    else if (advance)
      nextPC = fPC + PC_W'(1);
    else
      nextPC = fPC;
  end

  assign oImemAddr = irst_n ? nextPC : PC_W'(RESET_PC);

  always_comb begin
    stageD          = '0;
    stageD.valid    = 1'b1;
    stageD.pc       = fPC;
    stageD.opcode   = dOpcode;
    stageD.rd       = dWriteReg ? dRdField : '0;
    stageD.sr1      = dSr1;
    stageD.sr2      = dSr2;
    stageD.data1    = rdData1;
    stageD.data2    = rdData2;
    stageD.imm      = dImm;
    stageD.writeReg = dWriteReg;
    stageD.memRead  = (dOpcode == OP_LOAD);
    stageD.memWrite = (dOpcode == OP_STORE);
    stageD.aluSrc   = dIsMem;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      regs <= '{default: '0};
    end else if (iWbEn && (iWbAddr != '0)) begin
      regs[iWbAddr] <= iWbData;
    end
  end

  // A bubble clears the whole output bundle, which also zeroes controls and oImm.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      fPC    <= PC_W'(RESET_PC);
      dValid <= 1'b0;
      stageQ <= '0;
    end else begin
      fPC    <= nextPC;
      dValid <= !iRedirect;
      if (iRedirect)
        stageQ <= '0;
      else if (!iStall)
        stageQ <= advance ? stageD : '0;
    end
  end

  assign oValid    = stageQ.valid;
  assign oPC       = stageQ.pc;
  assign oOpcode   = stageQ.opcode;
  assign oRd       = stageQ.rd;
  assign oSr1      = stageQ.sr1;
  assign oSr2      = stageQ.sr2;
  assign oData1    = stageQ.data1;
  assign oData2    = stageQ.data2;
  assign oImm      = stageQ.imm;
  assign oWriteReg = stageQ.writeReg;
  assign oMemRead  = stageQ.memRead;
  assign oMemWrite = stageQ.memWrite;
  assign oALUSrc   = stageQ.aluSrc;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: default instance plus a 32-bit/32-reg one.
module tb_fetch_decode_stage;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic        iStall, iRedirect, iWbEn;
  logic [15:0] iRedirectPC;
  logic [3:0]  iWbAddr;
  logic [15:0] iWbData;
  logic [23:0] imemData, imemData32;
  logic [23:0] mem   [256];
  logic [23:0] mem32 [256];

  logic [15:0] oImemAddr, oPC, oData1, oData2, oImm;
  logic        oValid, oWriteReg, oMemRead, oMemWrite, oALUSrc;
  logic [4:0]  oOpcode;
  logic [3:0]  oRd, oSr1, oSr2;

  logic [15:0] oImemAddr32, oPC32;
  logic [31:0] oData1_32, oData2_32, oImm32;
  logic        oValid32, oWriteReg32, oMemRead32, oMemWrite32, oALUSrc32;
  logic [4:0]  oOpcode32, oRd32, oSr1_32, oSr2_32;

  int checks = 0;
  int errors = 0;

  fetch_decode_stage dut (
    .iclk(iclk), .irst_n(irst_n), .oImemAddr(oImemAddr), .iImemData(imemData),
    .iStall(iStall), .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
    .iWbEn(iWbEn), .iWbAddr(iWbAddr), .iWbData(iWbData),
    .oValid(oValid), .oPC(oPC), .oOpcode(oOpcode), .oRd(oRd), .oSr1(oSr1), .oSr2(oSr2),
    .oData1(oData1), .oData2(oData2), .oImm(oImm), .oWriteReg(oWriteReg),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oALUSrc(oALUSrc)
  );

  fetch_decode_stage #(.DATA_W(32), .NREGS(32)) dut32 (
    .iclk(iclk), .irst_n(irst_n), .oImemAddr(oImemAddr32), .iImemData(imemData32),
    .iStall(1'b0), .iRedirect(1'b0), .iRedirectPC(16'h0000),
    .iWbEn(1'b0), .iWbAddr(5'd0), .iWbData(32'h0),
    .oValid(oValid32), .oPC(oPC32), .oOpcode(oOpcode32), .oRd(oRd32), .oSr1(oSr1_32),
    .oSr2(oSr2_32), .oData1(oData1_32), .oData2(oData2_32), .oImm(oImm32),
    .oWriteReg(oWriteReg32), .oMemRead(oMemRead32), .oMemWrite(oMemWrite32),
    .oALUSrc(oALUSrc32)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) begin
    imemData   <= mem[oImemAddr[7:0]];
    imemData32 <= mem32[oImemAddr32[7:0]];
  end

  function automatic logic [23:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                     input logic [3:0] sr1, input logic [7:0] imm);
    return {3'b000, imm, sr1, rd, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = '0;
      mem32[i] = '0;
    end
    mem[0]     = mk(5'b01000, 4'd3, 4'd0, 8'h5A);
    mem[1]     = mk(5'b01010, 4'd2, 4'd1, 8'h04);
    mem[2]     = mk(5'b00000, 4'd4, 4'd2, 8'h03);
    mem[3]     = mk(5'b01001, 4'd5, 4'd0, 8'h12);
    mem[4]     = mk(5'b01011, 4'd7, 4'd1, 8'hF0);
    mem[5]     = mk(5'b00001, 4'd6, 4'd0, 8'h05);
    mem[6]     = mk(5'b01100, 4'd1, 4'd0, 8'h80);
    mem[7]     = mk(5'b00000, 4'd0, 4'd5, 8'h00);
    mem[8'h40] = mk(5'b01000, 4'd1, 4'd0, 8'h33);
    mem[8'hFF] = mk(5'b01000, 4'd2, 4'd0, 8'h01);
    mem32[0]   = mk(5'b01011, 4'd7, 4'd0, 8'h80);
    mem32[1]   = mk(5'b01001, 4'd3, 4'd0, 8'h90);

    irst_n = 1'b0; iStall = 1'b0; iRedirect = 1'b0; iRedirectPC = '0;
    iWbEn = 1'b0; iWbAddr = '0; iWbData = '0;

    tick(); tick();
    check("rst_valid", 32'(oValid), 32'h0);
    check("rst_pc", 32'(oPC), 32'h0);
    check("rst_addr", 32'(oImemAddr), 32'h0);
    check("rst_imm", 32'(oImm), 32'h0);

    irst_n = 1'b1; iWbEn = 1'b1; iWbAddr = 4'd3; iWbData = 16'h1111;
    tick();                                   // E1
    iWbEn = 1'b0;
    check("e1_valid", 32'(oValid), 32'h0);
    tick();                                   // E2
    check("first_valid", 32'(oValid), 32'h1);
    check("first_pc", 32'(oPC), 32'h0);
    check("first_imm", 32'(oImm), 32'h005A);
    check("first_rd", 32'(oRd), 32'h3);
    check("first_wr", 32'(oWriteReg), 32'h1);
    check("w32_imm", oImm32, 32'hFFFFFF80);
    check("w32_wr", 32'(oWriteReg32), 32'h0);
    check("w32_rd", 32'(oRd32), 32'h0);
    check("w32_mwr", 32'(oMemWrite32), 32'h1);

    tick();                                   // E3: Load r2
    check("load_pc", 32'(oPC), 32'h1);
    check("load_mrd", 32'(oMemRead), 32'h1);
    check("load_imm", 32'(oImm), 32'h0004);
    check("load_alusrc", 32'(oALUSrc), 32'h1);
    check("hazard_hold_addr", 32'(oImemAddr), 32'h2);
    check("w32_immh", oImm32, 32'hFFFF9000);

    tick();                                   // E4: bubble
    check("bubble_valid", 32'(oValid), 32'h0);
    check("bubble_mrd", 32'(oMemRead), 32'h0);
    check("bubble_wr", 32'(oWriteReg), 32'h0);
    check("after_bubble_addr", 32'(oImemAddr), 32'h3);

    tick();                                   // E5: ADD
    check("add_valid", 32'(oValid), 32'h1);
    check("add_pc", 32'(oPC), 32'h2);
    check("add_rd", 32'(oRd), 32'h4);
    check("add_data1", 32'(oData1), 32'h0);
    check("add_data2", 32'(oData2), 32'h1111);
    check("add_imm", 32'(oImm), 32'h0);

    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(oPC), 32'h2);
      check("stall_valid", 32'(oValid), 32'h1);
      check("stall_addr", 32'(oImemAddr), 32'h3);
    end
    iStall = 1'b0;
    tick();                                   // E9: ImmH
    check("immh_pc", 32'(oPC), 32'h3);
    check("immh_imm", 32'(oImm), 32'h1200);
    check("immh_rd", 32'(oRd), 32'h5);

    tick();                                   // E10: Store
    check("store_pc", 32'(oPC), 32'h4);
    check("store_imm", 32'(oImm), 32'hFFF0);
    check("store_wr", 32'(oWriteReg), 32'h0);
    check("store_rd", 32'(oRd), 32'h0);
    check("store_mwr", 32'(oMemWrite), 32'h1);

    iWbEn = 1'b1; iWbAddr = 4'd5; iWbData = 16'hBEEF;
    tick();                                   // E11: bypass on sr2=5
    check("bypass_pc", 32'(oPC), 32'h5);
    check("bypass_data2", 32'(oData2), 32'hBEEF);

    iWbAddr = 4'd0; iWbData = 16'hDEAD;
    tick();                                   // E12: DbLoad, r0 write
    check("dbload_imm", 32'(oImm), 32'hFF80);
    check("dbload_mrd", 32'(oMemRead), 32'h0);
    check("dbload_alusrc", 32'(oALUSrc), 32'h1);
    check("r0_data1", 32'(oData1), 32'h0);
    check("r0_data2", 32'(oData2), 32'h0);
    iWbEn = 1'b0;

    tick();                                   // E13: reads r5 from array
    check("r5_data1", 32'(oData1), 32'hBEEF);
    check("r5_pc", 32'(oPC), 32'h7);

    iStall = 1'b1; iRedirect = 1'b1; iRedirectPC = 16'h0040;
    #1;
    check("redir_addr_now", 32'(oImemAddr), 32'h0040);
    tick();                                   // E14
    iRedirect = 1'b0; iStall = 1'b0;
    #1;
    check("redir_valid1", 32'(oValid), 32'h0);
    check("redir_addr_hold", 32'(oImemAddr), 32'h0040);
    tick();
    check("redir_valid2", 32'(oValid), 32'h0);
    tick();
    check("redir_target_valid", 32'(oValid), 32'h1);
    check("redir_target_pc", 32'(oPC), 32'h0040);
    check("redir_target_imm", 32'(oImm), 32'h0033);

    iRedirect = 1'b1; iRedirectPC = 16'hFFFF;
    tick();
    iRedirect = 1'b0;
    #1;
    check("wrap_fetch_addr", 32'(oImemAddr), 32'hFFFF);
    tick();
    check("wrap_next_addr", 32'(oImemAddr), 32'h0000);
    tick();
    check("wrap_pc", 32'(oPC), 32'hFFFF);
    check("wrap_imm", 32'(oImm), 32'h0001);

    iStall = 1'b1;
    tick();
    #2;
    irst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(oValid), 32'h0);
    check("midrst_pc", 32'(oPC), 32'h0);
    check("midrst_addr", 32'(oImemAddr), 32'h0);
    check("midrst_imm", 32'(oImm), 32'h0);
    tick();
    iStall = 1'b0; irst_n = 1'b1;
    tick(); tick();
    check("rerun_valid", 32'(oValid), 32'h1);
    check("rerun_pc", 32'(oPC), 32'h0);
    check("rerun_imm", 32'(oImm), 32'h005A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
